// File: rtl/jesd_lmfc_gen.sv
// LMFC and frame-boundary generator for a 4-octet-per-clock JESD204 TX datapath.
// An octet counter is phase-aligned to SYSREF; per-lane multiframe/frame markers are decoded from it.
module jesd_lmfc_gen #(
    parameter int F          = 2,
    parameter int K          = 32,
    parameter int SYSREF_DLY = 0,
    parameter bit REALIGN    = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       LMFC_EN,
    input  logic       SYSREF,
    output logic       LMFC_SYNCED,
    output logic [3:0] LMFC_MS,
    output logic [3:0] LMFC_ME,
    output logic [3:0] FRM_S,
    output logic [3:0] FRM_E,
    output logic       SYSREF_ERR
);
    localparam int MF = F * K;
    localparam int MW = $clog2(MF);
    localparam int FW = (F > 1) ? $clog2(F) : 1;
    localparam int FS = FW + 3;

    localparam logic [MW:0]   MF_L    = (MW + 1)'(MF);
    localparam logic [MW:0]   MF_LAST = (MW + 1)'(MF - 1);
    localparam logic [FS-1:0] F_L     = FS'(F);
    localparam logic [FW-1:0] F_LAST  = FW'(F - 1);
    localparam logic [3:0]    DLY_L   = 4'(SYSREF_DLY);

    generate
        if (MF < 4) begin : g_mf_chk
            $error("jesd_lmfc_gen: F*K must be at least 4");
        end
        if (F < 1 || F > 256) begin : g_f_chk
            $error("jesd_lmfc_gen: F must be in 1..256");
        end
        if (SYSREF_DLY < 0 || SYSREF_DLY > 15) begin : g_dly_chk
            $error("jesd_lmfc_gen: SYSREF_DLY must be in 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_SYSREF = 2'd1,
        SYNCED      = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          sr_q1;
    logic          sr_q2;
    logic          sr_edge;
    logic          pend;
    logic [3:0]    dly_cnt;
    logic          align;
    logic [MW-1:0] mf_cnt;
    logic [FW-1:0] frm_cnt;
    logic [MW:0]   mf_sum;
    logic [MW-1:0] mf_nat;
    logic [FW-1:0] frm_nat;
    logic [MW:0]   mf_lane;
    logic [FW-1:0] frm_lane;

    // F may be smaller than 4, so one subtraction is not always enough.
    function automatic logic [FW-1:0] frm_mod(input logic [FS-1:0] v);
        logic [FS-1:0] t;
        t = v;
        for (int j = 0; j < 4; j++) begin
            if (t >= F_L) t = t - F_L;
        end
        return t[FW-1:0];
    endfunction

    assign sr_edge = sr_q1 & ~sr_q2;
    assign align   = pend && (dly_cnt == 4'd0) && (state != IDLE);
    assign mf_sum  = {1'b0, mf_cnt} + (MW + 1)'(4);
    assign mf_nat  = (mf_sum >= MF_L) ? MW'(mf_sum - MF_L) : mf_sum[MW-1:0];
    assign frm_nat = frm_mod({3'b000, frm_cnt} + FS'(4));

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (LMFC_EN) state_next = WAIT_SYSREF;
            WAIT_SYSREF: if (align) state_next = SYNCED;
            SYNCED:      state_next = SYNCED;
            default:     state_next = IDLE;
        endcase
        if (!LMFC_EN) state_next = IDLE;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sr_q1      <= 1'b0;
            sr_q2      <= 1'b0;
            pend       <= 1'b0;
            dly_cnt    <= 4'd0;
            mf_cnt     <= '0;
            frm_cnt    <= '0;
            SYSREF_ERR <= 1'b0;
        end else begin
            sr_q1 <= SYSREF;
            sr_q2 <= sr_q1;
            // The most recent SYSREF edge always restarts the delay.
            if (!LMFC_EN) begin
                pend    <= 1'b0;
                dly_cnt <= 4'd0;
            end else if (sr_edge) begin
                pend    <= 1'b1;
                dly_cnt <= DLY_L;
            end else if (pend) begin
                if (dly_cnt == 4'd0) pend <= 1'b0;
                else                 dly_cnt <= dly_cnt - 4'd1;
            end

            if (!LMFC_EN || state == IDLE) begin
                mf_cnt  <= '0;
                frm_cnt <= '0;
            end else if (align && (state == WAIT_SYSREF || REALIGN)) begin
                mf_cnt  <= '0;
                frm_cnt <= '0;
            end else begin
                mf_cnt  <= mf_nat;
                frm_cnt <= frm_nat;
            end

            // Compare the free-running phase against the boundary SYSREF asks for.
            SYSREF_ERR <= LMFC_EN && (state == SYNCED) && align &&
                          ((mf_nat != '0) || (frm_nat != '0));
        end
    end

    assign LMFC_SYNCED = (state == SYNCED);

    always_comb begin
        LMFC_MS  = 4'b0000;
        LMFC_ME  = 4'b0000;
        FRM_S    = 4'b0000;
        FRM_E    = 4'b0000;
        mf_lane  = '0;
        frm_lane = '0;
        for (int i = 0; i < 4; i++) begin
            mf_lane = {1'b0, mf_cnt} + (MW + 1)'(i);
            if (mf_lane >= MF_L) mf_lane = mf_lane - MF_L;
            frm_lane = frm_mod({3'b000, frm_cnt} + FS'(i));
            if (state == SYNCED) begin
                LMFC_MS[i] = (mf_lane == '0);
                LMFC_ME[i] = (mf_lane == MF_LAST);
                FRM_S[i]   = (frm_lane == '0);
                FRM_E[i]   = (frm_lane == F_LAST);
            end
        end
    end

endmodule

// File: tb/tb_jesd_lmfc_gen.sv
// Bench for jesd_lmfc_gen: four parameterisations, each driven on its own EN/SYSREF pair.
// Observed word per beat is {SYNCED, MS, ME, FRM_S, FRM_E, SYSREF_ERR}.
module tb_jesd_lmfc_gen;
    typedef logic [17:0] word_t;

    typedef struct {
        logic       sr;
        logic       syn;
        logic [3:0] ms;
        logic [3:0] me;
        logic [3:0] fs;
        logic [3:0] fe;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] en;
    logic [3:0] sr;
    logic       syn [4];
    logic [3:0] ms  [4];
    logic [3:0] me  [4];
    logic [3:0] fs  [4];
    logic [3:0] fe  [4];
    logic       err [4];

    word_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  sr_plan [256];
    logic  al_plan [256];
    vec_t  tbl [16];

    always #5 clk = ~clk;

    jesd_lmfc_gen #(.F(2), .K(32), .SYSREF_DLY(0), .REALIGN(1'b1)) u0 (
        .CLK(clk), .RST_n(rst_n), .LMFC_EN(en[0]), .SYSREF(sr[0]),
        .LMFC_SYNCED(syn[0]), .LMFC_MS(ms[0]), .LMFC_ME(me[0]),
        .FRM_S(fs[0]), .FRM_E(fe[0]), .SYSREF_ERR(err[0]));

    jesd_lmfc_gen #(.F(3), .K(4), .SYSREF_DLY(2), .REALIGN(1'b1)) u1 (
        .CLK(clk), .RST_n(rst_n), .LMFC_EN(en[1]), .SYSREF(sr[1]),
        .LMFC_SYNCED(syn[1]), .LMFC_MS(ms[1]), .LMFC_ME(me[1]),
        .FRM_S(fs[1]), .FRM_E(fe[1]), .SYSREF_ERR(err[1]));

    jesd_lmfc_gen #(.F(2), .K(32), .SYSREF_DLY(0), .REALIGN(1'b0)) u2 (
        .CLK(clk), .RST_n(rst_n), .LMFC_EN(en[2]), .SYSREF(sr[2]),
        .LMFC_SYNCED(syn[2]), .LMFC_MS(ms[2]), .LMFC_ME(me[2]),
        .FRM_S(fs[2]), .FRM_E(fe[2]), .SYSREF_ERR(err[2]));

    jesd_lmfc_gen #(.F(2), .K(32), .SYSREF_DLY(3), .REALIGN(1'b1)) u3 (
        .CLK(clk), .RST_n(rst_n), .LMFC_EN(en[3]), .SYSREF(sr[3]),
        .LMFC_SYNCED(syn[3]), .LMFC_MS(ms[3]), .LMFC_ME(me[3]),
        .FRM_S(fs[3]), .FRM_E(fe[3]), .SYSREF_ERR(err[3]));

    function automatic word_t obs(input int inst);
        return {syn[inst], ms[inst], me[inst], fs[inst], fe[inst], err[inst]};
    endfunction

    // Markers for a synced beat whose lane-0 octet index is p.
    function automatic word_t exp_word(input int p, input int mf, input int f, input bit e);
        logic [3:0] a, b, c, d;
        for (int i = 0; i < 4; i++) begin
            a[i] = ((p + i) % mf == 0);
            b[i] = ((p + i) % mf == mf - 1);
            c[i] = ((p + i) % f == 0);
            d[i] = ((p + i) % f == f - 1);
        end
        return {1'b1, a, b, c, d, e};
    endfunction

    function automatic vec_t v(input logic s, input logic y, input logic [3:0] a,
                               input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        vec_t r;
        r.sr = s; r.syn = y; r.ms = a; r.me = b; r.fs = c; r.fe = d;
        return r;
    endfunction

    task automatic check(input string name, input word_t got, input word_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, got, want);
        end
    endtask

    // Drive one beat, queue what the following edge must produce, then compare it.
    task automatic beat(input int inst, input logic e, input logic s, input word_t x,
                        input string name);
        word_t want;
        en[inst] = e;
        sr[inst] = s;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check(name, obs(inst), want);
    endtask

    task automatic clear_plan();
        for (int k = 0; k < 256; k++) begin
            sr_plan[k] = 1'b0;
            al_plan[k] = 1'b0;
        end
    endtask

    // al_plan marks the beats where SYSREF requests a boundary (sample + DLY + 2).
    task automatic run(input int inst, input int n, input int mf, input int f,
                       input bit realign, input string name);
        bit    synced;
        bit    e;
        int    base;
        int    nat;
        word_t x;
        synced = 1'b0;
        base   = 0;
        for (int k = 0; k < n; k++) begin
            e = 1'b0;
            if (al_plan[k]) begin
                nat = (4 * (k - base)) % mf;
                e = synced && (nat != 0);
                if (!synced || realign) base = k;
                synced = 1'b1;
            end
            x = synced ? exp_word((4 * (k - base)) % mf, mf, f, e) : '0;
            beat(inst, 1'b1, sr_plan[k], x, name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        en    = 4'b0000;
        sr    = 4'b0000;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 4; i++) check("in_reset", obs(i), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) check("after_reset", obs(i), '0);

        // F=3, K=4, DLY=2: SYSREF held high two beats, later an in-phase edge.
        for (int i = 0; i < 5; i++) tbl[i] = v((i == 1 || i == 2), 1'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        for (int i = 5; i < 16; i++) begin
            case ((i - 5) % 3)
                0:       tbl[i] = v(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b1001, 4'b0100);
                1:       tbl[i] = v(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0100, 4'b0010);
                default: tbl[i] = v(1'b0, 1'b1, 4'b0000, 4'b1000, 4'b0010, 4'b1001);
            endcase
        end
        tbl[10].sr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            beat(1, 1'b1, tbl[i].sr,
                 {tbl[i].syn, tbl[i].ms, tbl[i].me, tbl[i].fs, tbl[i].fe, 1'b0}, "f3_table");
        end

        // Single pulse, periodic in-phase pulses, a 1-beat shift, then in phase again.
        clear_plan();
        sr_plan[1] = 1'b1;   al_plan[3] = 1'b1;
        sr_plan[33] = 1'b1;  al_plan[35] = 1'b1;
        sr_plan[65] = 1'b1;  al_plan[67] = 1'b1;
        sr_plan[98] = 1'b1;  al_plan[100] = 1'b1;
        sr_plan[130] = 1'b1; al_plan[132] = 1'b1;
        run(0, 150, 64, 2, 1'b1, "realign_run");

        beat(0, 1'b0, 1'b0, '0, "en_drop");
        for (int i = 0; i < 10; i++) beat(0, 1'b1, 1'b0, '0, "no_resync");
        clear_plan();
        sr_plan[2] = 1'b1; al_plan[4] = 1'b1;
        run(0, 20, 64, 2, 1'b1, "resync");
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", obs(0), '0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) beat(0, 1'b1, 1'b0, '0, "post_rst");

        // REALIGN=0: shifted edge flags an error but the old phase is kept.
        clear_plan();
        sr_plan[1] = 1'b1;  al_plan[3] = 1'b1;
        sr_plan[34] = 1'b1; al_plan[36] = 1'b1;
        sr_plan[65] = 1'b1; al_plan[67] = 1'b1;
        run(2, 80, 64, 2, 1'b0, "keep_phase");

        // DLY=3: two edges one beat apart, only the second one aligns.
        clear_plan();
        sr_plan[2] = 1'b1;
        sr_plan[4] = 1'b1;
        al_plan[9] = 1'b1;
        run(3, 30, 64, 2, 1'b1, "double_edge");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
